// File: rtl/mxint8_block_dequant.sv
// MXINT8 block dequantiser: captures one shared-scale block, then streams each
// element out as an IEEE-754 single, one element per accepted handshake.
module mxint8_block_dequant #(
   parameter int BLOCK_SIZE           = 32,
   parameter int SCALE_WIDTH          = 8,
   parameter int MXINT8_ELEMENT_WIDTH = 8,
   parameter int FLOAT32_WIDTH        = 32
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic                                       i_valid,
   output logic                                       o_ready,
   input  logic [SCALE_WIDTH-1:0]                     i_scale,
   input  logic [BLOCK_SIZE*MXINT8_ELEMENT_WIDTH-1:0] i_mxint8_elements,
   output logic                                       o_valid,
   input  logic                                       i_ready,
   output logic [FLOAT32_WIDTH-1:0]                   o_float32,
   output logic [$clog2(BLOCK_SIZE)-1:0]              o_index,
   output logic                                       o_last,
   output logic                                       o_overflow
);

   localparam int IW  = $clog2(BLOCK_SIZE);
   localparam int EW  = MXINT8_ELEMENT_WIDTH;
   localparam int PW  = $clog2(EW);
   localparam int EXW = SCALE_WIDTH + 3;

   typedef enum logic {
      IDLE,
      BUSY
   } state_t;

   state_t                     state_q, state_d;
   logic [SCALE_WIDTH-1:0]     scale_q, scale_d;
   logic [BLOCK_SIZE*EW-1:0]   elems_q, elems_d;
   logic [IW-1:0]              idx_q, idx_d;

   logic                       busy;
   logic                       at_last;
   logic [EW-1:0]              elem;
   logic                       sign;
   logic [EW-1:0]              mag;
   logic [EW-1:0]              norm;
   logic [PW-1:0]              lead;
   logic signed [EXW-1:0]      exp_s;
   logic [22:0]                mant;
   logic [31:0]                f32;
   logic                       ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         scale_q <= '0;
         elems_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         scale_q <= scale_d;
         elems_q <= elems_d;
         idx_q   <= idx_d;
      end
   end

   assign busy    = (state_q == BUSY);
   assign at_last = (idx_q == IW'(BLOCK_SIZE - 1));

   always_comb begin
      state_d = state_q;
      scale_d = scale_q;
      elems_d = elems_q;
      idx_d   = idx_q;
      o_ready = 1'b0;
      o_valid = 1'b0;
      case (state_q)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid) begin
               scale_d = i_scale;
               elems_d = i_mxint8_elements;
               idx_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            o_valid = 1'b1;
            if (i_ready) begin
               if (at_last) begin
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign elem = elems_q[idx_q*EW +: EW];
   assign sign = elem[EW-1];
   // Two's-complement magnitude; the most negative code maps to 2^(EW-1), which still fits unsigned.
   assign mag  = sign ? (~elem + EW'(1)) : elem;

   always_comb begin
      lead = '0;
      for (int unsigned i = 0; i < EW; i++) begin
         if (mag[i]) lead = PW'(i);
      end
   end

   // Shift the leading one to the top so the remaining bits form the fraction, left-aligned.
   assign norm  = mag << (PW'(EW - 1) - lead);
   assign mant  = {norm[EW-2:0], {(24 - EW){1'b0}}};
   assign exp_s = $signed(EXW'(scale_q)) - $signed(EXW'(EW - 2)) + $signed(EXW'(lead));

   always_comb begin
      f32 = '0;
      ovf = 1'b0;
      if (scale_q == '1) begin
         f32 = 32'h7FC0_0000;
      end else if (mag == '0) begin
         f32 = '0;
      end else if (exp_s <= $signed(EXW'(0))) begin
         f32 = {sign, 31'b0};
      end else if (exp_s >= $signed(EXW'(255))) begin
         f32 = {sign, 8'hFF, 23'b0};
         ovf = 1'b1;
      end else begin
         f32 = {sign, exp_s[7:0], mant};
      end
   end

   assign o_float32  = busy ? FLOAT32_WIDTH'(f32) : '0;
   assign o_index    = idx_q;
   assign o_last     = busy && at_last;
   assign o_overflow = busy && ovf;

endmodule

// File: tb/tb_mxint8_block_dequant.sv
// Scoreboard bench: the driver pushes hand-computed element results at block
// capture; an independent negedge monitor pops and compares presented elements.
module tb_mxint8_block_dequant;

   typedef struct packed {
      logic [31:0] f;
      logic [4:0]  idx;
      logic        last;
      logic        ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         o_ready;
   logic [7:0]   i_scale;
   logic [255:0] i_mxint8_elements;
   logic         o_valid;
   logic         i_ready;
   logic [31:0]  o_float32;
   logic [4:0]   o_index;
   logic         o_last;
   logic         o_overflow;

   int unsigned  checks = 0;
   int unsigned  errors = 0;
   exp_t         sb[$];
   logic [31:0]  exp_f [32];
   logic         exp_o [32];

   // Directed table at scale 127: element code and its float32 result.
   logic [7:0]   tbl_e [8] = '{8'h40, 8'hC0, 8'h80, 8'h20, 8'h00, 8'h01, 8'h7F, 8'hFF};
   logic [31:0]  tbl_f [8] = '{32'h3F80_0000, 32'hBF80_0000, 32'hC000_0000, 32'h3F00_0000,
                               32'h0000_0000, 32'h3C80_0000, 32'h3FFE_0000, 32'hBC80_0000};

   mxint8_block_dequant #(
      .BLOCK_SIZE          (32),
      .SCALE_WIDTH         (8),
      .MXINT8_ELEMENT_WIDTH(8),
      .FLOAT32_WIDTH       (32)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .i_valid          (i_valid),
      .o_ready          (o_ready),
      .i_scale          (i_scale),
      .i_mxint8_elements(i_mxint8_elements),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_float32        (o_float32),
      .o_index          (o_index),
      .o_last           (o_last),
      .o_overflow       (o_overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h required %h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid) begin
            chk("o_ready_busy", 32'(o_ready), 32'd0);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_output got idx %0d required none", o_index);
            end else begin
               chk("float32", o_float32, sb[0].f);
               chk("index", 32'(o_index), 32'(sb[0].idx));
               chk("last", 32'(o_last), 32'(sb[0].last));
               chk("overflow", 32'(o_overflow), 32'(sb[0].ovf));
               if (i_ready) void'(sb.pop_front());
            end
         end else begin
            chk("overflow_idle", 32'(o_overflow), 32'd0);
         end
      end
   end

   task automatic start_block(input logic [7:0] sc, input logic [255:0] el);
      int unsigned n = 0;
      @(posedge clk); #1;
      while (!o_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_wait", 32'(o_ready), 32'd1);
      i_scale = sc;
      i_mxint8_elements = el;
      i_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 32; k++)
         sb.push_back('{f: exp_f[k], idx: 5'(k), last: (k == 31), ovf: exp_o[k]});
      #1;
   endtask

   task automatic finish_block(input bit rnd_ready, input bit hold_valid, output int unsigned cyc);
      cyc = 0;
      if (!hold_valid) i_valid = 1'b0;
      while (!o_ready && cyc < 400) begin
         if (rnd_ready) i_ready = 1'($urandom_range(0, 1));
         if (hold_valid) begin
            i_scale = 8'($urandom);
            i_mxint8_elements = {8{$urandom}};
         end
         @(posedge clk); #1;
         cyc++;
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      chk("block_done", 32'(o_ready), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic fill_table(output logic [255:0] el);
      for (int k = 0; k < 32; k++) begin
         el[k*8 +: 8] = tbl_e[k % 8];
         exp_f[k] = tbl_f[k % 8];
         exp_o[k] = 1'b0;
      end
   endtask

   task automatic fill_const(input logic [7:0] e, input logic [31:0] f, output logic [255:0] el);
      for (int k = 0; k < 32; k++) begin
         el[k*8 +: 8] = e;
         exp_f[k] = f;
         exp_o[k] = 1'b0;
      end
   endtask

   initial begin
      logic [255:0] el;
      int unsigned  cyc;
      int unsigned  n;

      rst = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b1;
      i_scale = '0;
      i_mxint8_elements = '0;
      #1;
      chk("rst_o_ready", 32'(o_ready), 32'd1);
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_float32", o_float32, 32'd0);
      chk("rst_index", 32'(o_index), 32'd0);
      chk("rst_last", 32'(o_last), 32'd0);
      chk("rst_overflow", 32'(o_overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // All ones at unit scale, full-rate drain.
      fill_const(8'h40, 32'h3F80_0000, el);
      start_block(8'd127, el);
      finish_block(1'b0, 1'b0, cyc);
      chk("throughput_cycles", cyc, 32'd32);

      // Mixed signs, most negative code, zero and fractions.
      fill_table(el);
      start_block(8'd127, el);
      finish_block(1'b0, 1'b0, cyc);

      // Top of range: 0x80 overflows, E=254 cases do not.
      fill_const(8'h00, 32'h0, el);
      el[7:0] = 8'h80;   exp_f[0] = 32'hFF80_0000; exp_o[0] = 1'b1;
      el[15:8] = 8'h40;  exp_f[1] = 32'h7F00_0000;
      el[23:16] = 8'h7F; exp_f[2] = 32'h7F7E_0000;
      el[31:24] = 8'hC0; exp_f[3] = 32'hFF00_0000;
      el[39:32] = 8'h01; exp_f[4] = 32'h7C00_0000;
      start_block(8'd254, el);
      finish_block(1'b0, 1'b0, cyc);

      // Bottom of range: E<=0 flushes to signed zero, E=1 survives.
      fill_const(8'h00, 32'h0, el);
      el[7:0] = 8'h01;   exp_f[0] = 32'h0000_0000;
      el[15:8] = 8'hFF;  exp_f[1] = 32'h8000_0000;
      el[23:16] = 8'h80; exp_f[2] = 32'h8080_0000;
      el[31:24] = 8'h40; exp_f[3] = 32'h0000_0000;
      el[39:32] = 8'hC0; exp_f[4] = 32'h8000_0000;
      start_block(8'd0, el);
      finish_block(1'b0, 1'b0, cyc);

      // NaN scale overrides every element.
      fill_const(8'h00, 32'h7FC0_0000, el);
      el = {8{$urandom}};
      start_block(8'hFF, el);
      finish_block(1'b0, 1'b0, cyc);

      // Random backpressure with i_valid held high and input data churning.
      fill_table(el);
      start_block(8'd127, el);
      finish_block(1'b1, 1'b1, cyc);

      // Asynchronous reset mid-block.
      fill_const(8'h40, 32'h3F80_0000, el);
      start_block(8'd127, el);
      i_valid = 1'b0;
      n = 0;
      while (!(o_valid && o_index == 5'd10) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_index10", 32'(o_index), 32'd10);
      #1 rst = 1'b1;
      #1;
      chk("midrst_o_valid", 32'(o_valid), 32'd0);
      chk("midrst_o_ready", 32'(o_ready), 32'd1);
      chk("midrst_index", 32'(o_index), 32'd0);
      chk("midrst_float32", o_float32, 32'd0);
      sb.delete();
      @(posedge clk); #1 rst = 1'b0;

      fill_table(el);
      start_block(8'd127, el);
      finish_block(1'b0, 1'b0, cyc);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
